// File: rtl/fdiv_iter.sv
// Iterative binary32 divider: y = x1 / x2.
// Restoring radix-2 mantissa division with a fixed 27-cycle latency
// (1 normalise + 25 quotient bits + 1 round/pack), one operation in flight.
module fdiv_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [2:0] {IDLE, NORM, DIV, ROUND, DONE} state_t;

    state_t state, state_nxt;

    logic               s1, s2;
    logic        [7:0]  e1, e2;
    logic        [23:0] ma, mb;
    logic               z1, z2;
    logic        [24:0] rem;
    logic        [24:0] q;
    logic        [4:0]  cnt;
    logic signed [9:0]  e;

    // Round the 24-bit mantissa on the guard bit (half up, no sticky),
    // then select zero/infinity/normal result by priority.
    function automatic logic [31:0] round_pack(
        input logic               sign,
        input logic signed [9:0]  exp_in,
        input logic        [24:0] quo,
        input logic               zero_a,
        input logic               zero_b
    );
        logic        [24:0] m;
        logic signed [9:0]  ex;
        m  = {1'b0, quo[24:1]} + {24'd0, quo[0]};
        ex = exp_in;
        // Carry out of rounding makes the mantissa exactly 2^24: the fraction
        // bits are already zero, only the exponent moves.
        if (m[24])
            ex = ex + 10'sd1;
        if (zero_b)
            return {sign, 8'hFF, 23'h0};
        else if (zero_a)
            return {sign, 31'h0};
        else if (ex <= 10'sd0)
            return {sign, 31'h0};
        else if (ex >= 10'sd255)
            return {sign, 8'hFF, 23'h0};
        else
            return {sign, ex[7:0], m[22:0]};
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; out_ready only matters once the result is posted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)      state_nxt = NORM;
            NORM:                       state_nxt = DIV;
            DIV:     if (cnt == 5'd24)  state_nxt = ROUND;
            ROUND:                      state_nxt = DONE;
            DONE:    if (out_ready)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Operand capture, normalisation and one quotient bit per DIV cycle.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (in_valid) begin
                    s1 <= x1[31];
                    s2 <= x2[31];
                    e1 <= x1[30:23];
                    e2 <= x2[30:23];
                    ma <= {1'b1, x1[22:0]};
                    mb <= {1'b1, x2[22:0]};
                end
            end
            NORM: begin
                z1  <= (e1 == 8'd0);
                z2  <= (e2 == 8'd0);
                cnt <= 5'd0;
                q   <= 25'd0;
                // Pre-shift a smaller dividend so the first quotient bit is 1.
                if (ma >= mb) begin
                    rem <= {1'b0, ma};
                    e   <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
                end else begin
                    rem <= {ma, 1'b0};
                    e   <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd126;
                end
            end
            DIV: begin
                if (rem >= {1'b0, mb}) begin
                    rem <= (rem - {1'b0, mb}) << 1;
                    q   <= {q[23:0], 1'b1};
                end else begin
                    rem <= rem << 1;
                    q   <= {q[23:0], 1'b0};
                end
                cnt <= cnt + 5'd1;
            end
            default: ;
        endcase
    end

    // Result register: written once per operation in ROUND, held otherwise.
    always_ff @(posedge clk) begin
        if (rst)
            y <= 32'h0;
        else if (state == ROUND)
            y <= round_pack(s1 ^ s2, e, q, z1, z2);
    end

endmodule

// File: tb/tb_fdiv_iter.sv
// Self-checking bench for fdiv_iter: directed cases, handshake/back-pressure,
// reset mid-operation and randomized operands against an integer-division model.
module tb_fdiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x1, x2;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    fdiv_iter dut (
        .clk       (clk),
        .rst       (rst),
        .x1        (x1),
        .x2        (x2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: full-width integer quotient of the significands, then
    // round-half-up on the bit below the 24-bit mantissa.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int         ea, eb, ex;
        longint     sa, sb, qq, m;
        logic       sg;
        logic [7:0] exb;
        logic [22:0] fr;
        sg = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        sa = longint'({1'b1, a[22:0]});
        sb = longint'({1'b1, b[22:0]});
        if (eb == 0) return {sg, 8'hFF, 23'h0};
        if (ea == 0) return {sg, 31'h0};
        if (sa >= sb) begin
            qq = (sa << 24) / sb;
            ex = ea - eb + 127;
        end else begin
            qq = (sa << 25) / sb;
            ex = ea - eb + 126;
        end
        m = (qq >> 1) + (qq & 1);
        if (m >= (64'sd1 << 24)) begin
            ex = ex + 1;
            m  = 0;
        end
        if (ex <= 0)   return {sg, 31'h0};
        if (ex >= 255) return {sg, 8'hFF, 23'h0};
        exb = ex[7:0];
        fr  = m[22:0];
        return {sg, exb, fr};
    endfunction

    // Issue one operation and wait (bounded) for out_valid; result left in DONE.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] yo, output int lat, output logic busy_ok);
        @(negedge clk);
        x1 = a;
        x2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x1 = $urandom;
        x2 = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        yo = y;
    endtask

    task automatic retire();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input bit chk_lat);
        logic [31:0] yo;
        int          lat;
        logic        busy_ok;
        do_op(a, b, yo, lat, busy_ok);
        chk(tag, yo, exp);
        if (chk_lat) begin
            chk({tag, "_lat"}, 32'(lat), 32'd27);
            chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        end
        retire();
    endtask

    initial begin
        logic [31:0] yo, yhold, a, b;
        int          lat;
        logic        busy_ok, seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x1 = '0; x2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_y", y, 32'h0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic and special cases
        run_case("6div2",    32'h40C00000, 32'h40000000, 32'h40400000, 1'b1);
        run_case("1div3",    32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b1);
        run_case("1div1",    32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
        run_case("m7p5div2p5", 32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0);
        run_case("m1div0",   32'hBF800000, 32'h00000000, 32'hFF800000, 1'b0);
        run_case("0div5",    32'h00000000, 32'h40A00000, 32'h00000000, 1'b0);
        run_case("0div0",    32'h00000000, 32'h00000000, 32'h7F800000, 1'b0);
        run_case("subn",     32'h00000001, 32'h3F800000, 32'h00000000, 1'b0);
        run_case("uflow",    32'h00800000, 32'h40000000, 32'h00000000, 1'b0);
        run_case("oflow",    32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0);
        run_case("nooflow",  32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0);

        // Back-pressure in DONE, ignored in_valid, then back-to-back accept
        do_op(32'h40C00000, 32'h40000000, yhold, lat, busy_ok);
        chk("bp_first", yhold, 32'h40400000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            x1 = 32'h3F800000;
            x2 = 32'h40400000;
            @(posedge clk);
            #1;
            chk("bp_y", y, yhold);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        retire();
        chk("bp_ready_after", {31'd0, in_ready}, 32'd1);
        chk("bp_valid_after", {31'd0, out_valid}, 32'd0);
        do_op(32'hC0F00000, 32'h40200000, yo, lat, busy_ok);
        chk("b2b_y", yo, 32'hC0400000);
        chk("b2b_lat", 32'(lat), 32'd27);
        retire();

        // Reset during DIV
        @(negedge clk);
        x1 = 32'h3F800000; x2 = 32'h40400000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_y", y, 32'h0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("no_spurious", {31'd0, seen}, 32'd0);
        run_case("post_rst_6div2", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b1);

        // Randomized operands against the model
        for (int i = 0; i < 60; i++) begin
            if (i % 2 == 0) begin
                a = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
                b = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
            end else begin
                a = $urandom;
                b = $urandom;
            end
            do_op(a, b, yo, lat, busy_ok);
            chk("rand_y", yo, ref_div(a, b));
            chk("rand_lat", 32'(lat), 32'd27);
            retire();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
